display_scan_ctrl: RTL and testbench

Refresh scheduler for the 3-digit multiplexed 7-segment display. It generates the time-slotted anode scan and inserts a dead-time guard at the start of each slot to suppress ghosting. Segment patterns come from BCD digits. New digit values are only committed at frame boundaries, so a displayed number never tears mid-frame. It sits between the board clock/reset and the display pins, and replaces free-running counter/toggle anode generation.

---
 rtl/display_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-slotted anode scanner for a 3-digit multiplexed 7-segment display.
// Each slot opens with a dead-time guard. New digits are committed only at frame boundaries.
module display_scan_ctrl #(
    parameter int SLOT  = 80000,
    parameter int GUARD = 2000,
    parameter int CW    = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [2:0] blank,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       pending
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [2:0] blank;
    } disp_set_t;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    disp_set_t       act_q, act_d;
    disp_set_t       pset_q, pset_d;
    logic            pend_q, pend_d;
    logic [2:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;

    disp_set_t       in_set;
    logic            scan_run;
    logic            slot_end;
    logic            boundary;
    logic [3:0]      cur_digit;
    logic            cur_blank;
    logic [2:0]      cur_an;

    // Active-low gfedcba; codes above 9 render as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign in_set   = '{d2: d2, d1: d1, d0: d0, blank: blank};
    // Dropping en in SCAN behaves like IDLE at once: no boundary, no anode.
    assign scan_run = (state_q == ST_SCAN) && en;
    assign slot_end = scan_run && (cnt_q == SLOT_LAST);
    assign boundary = slot_end && (idx_q == 2'd2);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cur_digit = act_q.d2;
        cur_blank = act_q.blank[2];
        cur_an    = 3'b011;
        case (idx_q)
            2'd0: begin
                cur_digit = act_q.d0;
                cur_blank = act_q.blank[0];
                cur_an    = 3'b110;
            end
            2'd1: begin
                cur_digit = act_q.d1;
                cur_blank = act_q.blank[1];
                cur_an    = 3'b101;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pset_d  = pset_q;
        pend_d  = pend_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = 2'd0;
                if (load) begin
                    act_d = in_set;
                end
                if (en) begin
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    if (load) begin
                        pset_d = in_set;
                        pend_d = 1'b1;
                    end
                end else begin
                    if (slot_end) begin
                        cnt_d = '0;
                        idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end

                    // A load on the boundary bypasses the pending stage entirely.
                    if (boundary) begin
                        if (load) begin
                            act_d  = in_set;
                            pend_d = 1'b0;
                        end else if (pend_q) begin
                            act_d  = pset_q;
                            pend_d = 1'b0;
                        end
                    end else if (load) begin
                        pset_d = in_set;
                        pend_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        an_d  = 3'b111;
        seg_d = 7'b1111111;
        fd_d  = boundary;
        if (scan_run && (cnt_q >= GUARD_END) && !cur_blank) begin
            an_d  = cur_an;
            seg_d = seg_decode(cur_digit);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            act_q   <= '0;
            pset_q  <= '0;
            pend_q  <= 1'b0;
            an_q    <= 3'b111;
            seg_q   <= 7'b1111111;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pset_q  <= pset_d;
            pend_q  <= pend_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT=10, GUARD=2.
// A timed vector table covers scan timing and loads; hand sequences cover en drop and reset.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] d0, d1, d2;
    logic [2:0] blank;
    logic [2:0] an;
    logic [6:0] seg;
    logic       frame_done;
    logic       pending;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(.SLOT(10), .GUARD(2), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic       en;
        logic       load;
        logic [3:0] d0, d1, d2;
        logic [2:0] blank;
        int         n;
        logic [2:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic [2:0] ean, input logic [6:0] eseg,
                              input logic efd, input logic epd);
        check({nm, ".an"}, 16'(an), 16'(ean));
        check({nm, ".seg"}, 16'(seg), 16'(eseg));
        check({nm, ".frame_done"}, 16'(frame_done), 16'(efd));
        check({nm, ".pending"}, 16'(pending), 16'(epd));
    endtask

    task automatic add(input string nm, input logic e, input logic ld,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [2:0] bl, input int n, input logic [2:0] ean,
                       input logic [6:0] eseg, input logic efd, input logic epd);
        vec_t v;
        v.name = nm; v.en = e; v.load = ld; v.d0 = a; v.d1 = b; v.d2 = c;
        v.blank = bl; v.n = n; v.an = ean; v.seg = eseg; v.fd = efd; v.pend = epd;
        vecs.push_back(v);
    endtask

    task automatic wait_frame_done(input string nm, input int budget, output int cycles);
        cycles = 0;
        while (frame_done !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        if (frame_done !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL %s: frame_done not seen within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int cyc;
        int fd_seen;

        // name, en, load, d0, d1, d2, blank, cycles, an, seg, frame_done, pending
        add("preload",     0, 1, 1, 2, 3, 3'b000, 1, 3'b111, OFF, 0, 0);
        add("scan_c0",     1, 0, 0, 0, 0, 3'b000, 1, 3'b111, OFF, 0, 0);
        add("guard_c2",    1, 0, 0, 0, 0, 3'b000, 2, 3'b111, OFF, 0, 0);
        add("an0_c3",      1, 0, 0, 0, 0, 3'b000, 1, 3'b110, S1,  0, 0);
        add("an0_c10",     1, 0, 0, 0, 0, 3'b000, 7, 3'b110, S1,  0, 0);
        add("guard_c11",   1, 0, 0, 0, 0, 3'b000, 1, 3'b111, OFF, 0, 0);
        add("an1_c13",     1, 0, 0, 0, 0, 3'b000, 2, 3'b101, S2,  0, 0);
        add("an1_c20",     1, 0, 0, 0, 0, 3'b000, 7, 3'b101, S2,  0, 0);
        add("guard_c22",   1, 0, 0, 0, 0, 3'b000, 2, 3'b111, OFF, 0, 0);
        add("an2_c23",     1, 0, 0, 0, 0, 3'b000, 1, 3'b011, S3,  0, 0);
        add("an2_c29",     1, 0, 0, 0, 0, 3'b000, 6, 3'b011, S3,  0, 0);
        add("fd_c30",      1, 0, 0, 0, 0, 3'b000, 1, 3'b011, S3,  1, 0);
        add("fd_off_c31",  1, 0, 0, 0, 0, 3'b000, 1, 3'b111, OFF, 0, 0);
        add("an0_c33",     1, 0, 0, 0, 0, 3'b000, 2, 3'b110, S1,  0, 0);
        add("slot1_c45",   1, 0, 0, 0, 0, 3'b000, 12, 3'b101, S2, 0, 0);
        add("load789",     1, 1, 7, 8, 9, 3'b000, 1, 3'b101, S2,  0, 1);
        add("held_c53",    1, 0, 0, 0, 0, 3'b000, 7, 3'b011, S3,  0, 1);
        add("held_c59",    1, 0, 0, 0, 0, 3'b000, 6, 3'b011, S3,  0, 1);
        add("commit_c60",  1, 0, 0, 0, 0, 3'b000, 1, 3'b011, S3,  1, 0);
        add("new7_c63",    1, 0, 0, 0, 0, 3'b000, 3, 3'b110, S7,  0, 0);
        add("load456b",    1, 1, 4, 5, 6, 3'b010, 1, 3'b110, S7,  0, 1);
        add("commit_c90",  1, 0, 0, 0, 0, 3'b000, 26, 3'b011, S9, 1, 0);
        add("d4_c93",      1, 0, 0, 0, 0, 3'b000, 3, 3'b110, S4,  0, 0);
        add("blank_c103",  1, 0, 0, 0, 0, 3'b000, 10, 3'b111, OFF, 0, 0);
        add("blank_c110",  1, 0, 0, 0, 0, 3'b000, 7, 3'b111, OFF, 0, 0);
        add("d6_c113",     1, 0, 0, 0, 0, 3'b000, 3, 3'b011, S6,  0, 0);
        add("blank_c119",  1, 0, 0, 0, 0, 3'b000, 6, 3'b011, S6,  0, 0);
        add("blank_fd120", 1, 0, 0, 0, 0, 3'b000, 1, 3'b011, S6,  1, 0);
        add("wrap_c149",   1, 0, 0, 0, 0, 3'b000, 29, 3'b011, S6, 0, 0);
        add("wrap_load",   1, 1, 9, 0, 5, 3'b000, 1, 3'b011, S6,  1, 0);
        add("wrap_d9",     1, 0, 0, 0, 0, 3'b000, 3, 3'b110, S9,  0, 0);
        add("pre_2load",   1, 0, 0, 0, 0, 3'b000, 2, 3'b110, S9,  0, 0);
        add("load_first",  1, 1, 2, 2, 2, 3'b000, 1, 3'b110, S9,  0, 1);
        add("between",     1, 0, 0, 0, 0, 3'b000, 2, 3'b110, S9,  0, 1);
        add("load_second", 1, 1, 6, 3, 7, 3'b000, 1, 3'b110, S9,  0, 1);
        add("commit_c180", 1, 0, 0, 0, 0, 3'b000, 21, 3'b011, 7'b0010010, 1, 0);
        add("second_d0",   1, 0, 0, 0, 0, 3'b000, 3, 3'b110, S6,  0, 0);
        add("second_d1",   1, 0, 0, 0, 0, 3'b000, 10, 3'b101, S3, 0, 0);

        rst = 1'b0; en = 1'b0; load = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; blank = '0;
        step();
        step();
        check_outs("reset", 3'b111, OFF, 1'b0, 1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; load = vecs[i].load;
            d0 = vecs[i].d0; d1 = vecs[i].d1; d2 = vecs[i].d2; blank = vecs[i].blank;
            repeat (vecs[i].n) step();
            check_outs(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].fd, vecs[i].pend);
        end
        load = 1'b0; blank = '0;

        // en dropped mid slot 2 with a pending set outstanding
        repeat (12) step();
        d0 = 4; d1 = 4; d2 = 4; load = 1'b1;
        step();
        load = 1'b0;
        check_outs("drop_pre", 3'b011, S7, 1'b0, 1'b1);
        en = 1'b0;
        step();
        check_outs("drop_off", 3'b111, OFF, 1'b0, 1'b1);
        fd_seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame_done === 1'b1) fd_seen++;
        end
        check("idle_no_frame_done", 16'(fd_seen), 16'd0);
        en = 1'b1;
        step();
        check_outs("reenable_s0", 3'b111, OFF, 1'b0, 1'b1);
        repeat (3) step();
        check_outs("reenable_old", 3'b110, S6, 1'b0, 1'b1);
        wait_frame_done("reenable_wrap", 100, cyc);
        check("reenable_wrap_cycles", 16'(cyc), 16'd27);
        check_outs("reenable_commit", 3'b011, S7, 1'b1, 1'b0);
        repeat (3) step();
        check_outs("reenable_new", 3'b110, S4, 1'b0, 1'b0);

        // dash code, then a one-cycle reset mid-slot
        d0 = 4'hC; d1 = 4'hC; d2 = 4'hC; load = 1'b1;
        step();
        load = 1'b0;
        wait_frame_done("dash_wrap", 100, cyc);
        check("dash_wrap_cycles", 16'(cyc), 16'd26);
        repeat (3) step();
        check_outs("dash_seg", 3'b110, DASH, 1'b0, 1'b0);
        step();
        d0 = 1; d1 = 1; d2 = 1; load = 1'b1;
        step();
        load = 1'b0;
        check_outs("pre_reset", 3'b110, DASH, 1'b0, 1'b1);
        rst = 1'b0;
        step();
        check_outs("mid_reset", 3'b111, OFF, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_outs("post_reset_s0", 3'b111, OFF, 1'b0, 1'b0);
        repeat (3) step();
        check_outs("post_reset_zero", 3'b110, S0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
